// File: rtl/dezigzag_if.sv
// Stream bundle for the 8x8 de-zigzag block: zigzag-ordered coefficients in,
// raster-ordered coefficients out, each side with a valid/ready handshake.
interface dezigzag_if #(
  parameter int DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [5:0]            out_addr;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_addr, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_addr, out_valid, out_last
  );
endinterface

// File: rtl/dezigzag.sv
// Ping-pong 8x8 reorder buffer: a zigzag walker writes one bank while the
// other bank is streamed out in raster order through a registered read port.
module dezigzag #(
  parameter int DATA_WIDTH = 10
) (
  input logic       clk,
  input logic       rst_n,
  dezigzag_if.slave bus
);

  logic [2:0]            x_q, x_d;
  logic [2:0]            y_q, y_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [1:0]            full_q, full_d;
  logic [5:0]            rd_cnt_q, rd_cnt_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [5:0]            out_addr_q, out_addr_d;
  logic                  out_last_q, out_last_d;

  // Bank select is the top address bit; the two banks never collide because a
  // bank is either being filled (not full) or being drained (full).
  logic [DATA_WIDTH-1:0] mem [0:127];

  logic in_ready;
  logic wr_fire;
  logic wr_end;
  logic rd_fire;
  logic rd_end;
  logic dir;

  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = bus.in_valid && in_ready;
  assign wr_end   = wr_fire && (x_q == 3'd7) && (y_q == 3'd7);
  assign rd_fire  = full_q[rd_bank_q] && (!out_valid_q || bus.out_ready);
  assign rd_end   = rd_fire && (rd_cnt_q == 6'd63);
  assign dir      = x_q[0] ^ y_q[0];

  // Zigzag walker: even anti-diagonal parity moves up-right, odd moves down-left,
  // bouncing along the block edges.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (wr_end) begin
      x_d = 3'd0;
      y_d = 3'd0;
    end else if (wr_fire) begin
      if (!dir) begin
        if (x_q == 3'd7) begin
          y_d = y_q + 3'd1;
        end else if (y_q == 3'd0) begin
          x_d = x_q + 3'd1;
        end else begin
          x_d = x_q + 3'd1;
          y_d = y_q - 3'd1;
        end
      end else begin
        if (y_q == 3'd7) begin
          x_d = x_q + 3'd1;
        end else if (x_q == 3'd0) begin
          y_d = y_q + 3'd1;
        end else begin
          x_d = x_q - 3'd1;
          y_d = y_q + 3'd1;
        end
      end
    end
  end

  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    full_d      = full_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;

    if (wr_end) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end
    if (rd_end) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end

    if (rd_fire) begin
      rd_cnt_d    = rd_cnt_q + 6'd1;
      out_valid_d = 1'b1;
      out_addr_d  = rd_cnt_q;
      out_last_d  = (rd_cnt_q == 6'd63);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= 3'd0;
      y_q         <= 3'd0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= 2'b00;
      rd_cnt_q    <= 6'd0;
      out_valid_q <= 1'b0;
      out_addr_q  <= 6'd0;
      out_last_q  <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[{wr_bank_q, y_q, x_q}] <= bus.in_data;
    end
  end

  // Read data register doubles as the output register; it only loads on a fire
  // so a stalled element stays put.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
    end else if (rd_fire) begin
      out_data_q <= mem[{rd_bank_q, rd_cnt_q}];
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;

endmodule
